// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch stage and
// the downstream controller/decoder.
//   fetch_state_t : fetch FSM state encoding
//   OPCODE_W      : width of the opcode field at the top of each instruction
//   OPC_PFX_*     : top two opcode bits that select the instruction class
package fetch_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

  localparam int OPCODE_W = 6;

  // The controller classifies instructions by the two MSBs of the opcode.
  localparam int         OPC_PFX_W   = 2;
  localparam logic [1:0] OPC_PFX_REG = 2'b00;
  localparam logic [1:0] OPC_PFX_IMM = 2'b01;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: owns the program counter, fetches one word at a time from
// instruction memory over a req/ack handshake, holds it in an output register
// for decode (valid/ready), and squashes stale fetches on branch redirects.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      request to instruction memory (registered)
//   imem_ack, imem_rdata     response strobe and same-cycle data
//   br_valid, br_target      single-cycle redirect from execute
//   instr_valid, instr_ready decode handshake
//   instr_out, opcode        held instruction word and its opcode slice
//   pc_out                   address instr_out was fetched from
//
// state  | meaning
// S_REQ  | request to memory outstanding (or being launched out of reset)
// S_HOLD | fetched word presented to decode, waiting for ready
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                INSTR_W  = 19,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                br_valid,
  input  logic [ADDR_W-1:0]   br_target,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   pc_out
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d;
  logic               discard_q, discard_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  fetch_pc;

  // Address of the next fresh request: a redirect this cycle wins over pc.
  assign fetch_pc = br_valid ? br_target : pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    req_d     = req_q;
    discard_d = discard_q;
    valid_d   = valid_q;

    if (br_valid) begin
      pc_d    = br_target;
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (!req_q) begin
          // Only reachable right after reset: launch the first request.
          req_d  = 1'b1;
          addr_d = fetch_pc;
        end else if (imem_ack) begin
          if (br_valid || discard_q) begin
            // Response belongs to a squashed path; drop it and refetch.
            discard_d = 1'b0;
            addr_d    = fetch_pc;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
            req_d    = 1'b0;
            state_d  = S_HOLD;
          end
        end else if (br_valid) begin
          // The in-flight request cannot be withdrawn; mark its data stale.
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_valid || (valid_q && instr_ready)) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = fetch_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      pc_out_q  <= '0;
      instr_q   <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      pc_out_q  <= pc_out_d;
      instr_q   <= instr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed walk through the fetch scenarios followed by
// randomized memory latency / ready / redirect traffic checked against a
// transaction-level model of the fetch stream.
module tb_instr_fetch;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [5:0]         opcode;
  logic [ADDR_W-1:0]  pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder controls
  int wait_cnt = 0;
  int ack_lat  = 0;
  bit rnd_ack  = 1'b0;
  bit mem_scr  = 1'b0;

  // model state
  logic [ADDR_W-1:0]  exp_pc;
  logic [ADDR_W-1:0]  cur_req_addr;
  logic               prev_req, prev_ack, stale;
  logic               want_req, want_same_addr, want_valid, want_hold, want_drop;
  logic [ADDR_W-1:0]  want_pcout;
  logic [INSTR_W-1:0] want_instr;

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a, input bit scr);
    logic [31:0] h;
    h = (32'(a) * 32'h0000_9E37) ^ 32'h0005_A5A5;
    if (scr) return h[INSTR_W-1:0];
    return INSTR_W'(a) + INSTR_W'(32'h100);
  endfunction

  assign imem_rdata = mem_word(imem_addr, mem_scr);

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .opcode      (opcode),
    .pc_out      (pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc         = 12'h000;
    cur_req_addr   = 12'h000;
    prev_req       = 1'b0;
    prev_ack       = 1'b0;
    stale          = 1'b0;
    want_req       = 1'b0;
    want_same_addr = 1'b0;
    want_valid     = 1'b0;
    want_hold      = 1'b0;
    want_drop      = 1'b0;
    want_pcout     = '0;
    want_instr     = '0;
  endtask

  // Checks what the previous edge should have produced, then records what the
  // coming edge must do given the current inputs and outputs.
  task automatic observe();
    logic [INSTR_W-1:0] w;
    if (want_req)       chk("req_next", 32'(imem_req), 32'h1);
    if (want_same_addr) chk("req_addr_hold", 32'(imem_addr), 32'(cur_req_addr));
    if (want_valid) begin
      chk("valid_rise", 32'(instr_valid), 32'h1);
      chk("pc_out_fetch", 32'(pc_out), 32'(want_pcout));
      chk("instr_fetch", 32'(instr_out), 32'(want_instr));
      chk("req_low_hold", 32'(imem_req), 32'h0);
    end
    if (want_hold) begin
      chk("hold_valid", 32'(instr_valid), 32'h1);
      chk("hold_pc_out", 32'(pc_out), 32'(want_pcout));
      chk("hold_instr", 32'(instr_out), 32'(want_instr));
      chk("hold_no_req", 32'(imem_req), 32'h0);
    end
    if (want_drop) chk("valid_drop", 32'(instr_valid), 32'h0);
    if (imem_req && !(prev_req && !prev_ack)) begin
      chk("req_addr", 32'(imem_addr), 32'(exp_pc));
      cur_req_addr = exp_pc;
    end

    want_req = 1'b0; want_same_addr = 1'b0; want_valid = 1'b0;
    want_hold = 1'b0; want_drop = 1'b0;

    if (instr_valid && instr_ready && !br_valid) begin
      w = mem_word(exp_pc, mem_scr);
      chk("pc_seq", 32'(pc_out), 32'(exp_pc));
      chk("data", 32'(instr_out), 32'(w));
      chk("opcode", 32'(opcode), 32'(w[18:13]));
      exp_pc   = exp_pc + 12'd1;
      want_req = 1'b1;
    end
    if (instr_valid && !instr_ready && !br_valid) begin
      want_hold  = 1'b1;
      want_pcout = exp_pc;
      want_instr = mem_word(exp_pc, mem_scr);
    end
    if (br_valid) begin
      exp_pc    = br_target;
      want_drop = 1'b1;
      if (!(imem_req && !imem_ack)) want_req = 1'b1;
    end
    if (imem_req && !imem_ack) begin
      want_req       = 1'b1;
      want_same_addr = 1'b1;
      if (br_valid) stale = 1'b1;
    end
    if (imem_req && imem_ack) begin
      if (br_valid || stale) want_req = 1'b1;
      else begin
        want_valid = 1'b1;
        want_pcout = cur_req_addr;
        want_instr = mem_word(cur_req_addr, mem_scr);
      end
      stale = 1'b0;
    end
    prev_req = imem_req;
    prev_ack = imem_ack;
  endtask

  task automatic respond();
    if (!imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (rnd_ack) begin
      imem_ack = ($urandom_range(0, 1) == 0);
    end else begin
      imem_ack = (wait_cnt >= ack_lat);
      wait_cnt = imem_ack ? 0 : wait_cnt + 1;
    end
  endtask

  task automatic cycle();
    observe();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic wait_valid(input int budget);
    for (int k = 0; k < budget && !instr_valid; k++) cycle();
    chk("valid_wait", 32'(instr_valid), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; br_valid = 1'b0; br_target = '0; instr_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h000);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    rst = 1'b0;
    instr_ready = 1'b1;
    ack_lat = 0;

    // zero-wait streaming: one instruction every two cycles
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stream_req", 32'(imem_req), 32'h1);
      chk("stream_addr", 32'(imem_addr), 32'(i));
      chk("stream_valid_lo", 32'(instr_valid), 32'h0);
      cycle();
      chk("stream_valid", 32'(instr_valid), 32'h1);
      chk("stream_pc_out", 32'(pc_out), 32'(i));
      chk("stream_instr", 32'(instr_out), 32'h100 + 32'(i));
      chk("stream_req_lo", 32'(imem_req), 32'h0);
    end

    // memory holds ack for three cycles
    ack_lat = 3;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("slow_req", 32'(imem_req), 32'h1);
      chk("slow_addr", 32'(imem_addr), 32'h003);
      chk("slow_valid_lo", 32'(instr_valid), 32'h0);
    end
    cycle();
    chk("slow_valid", 32'(instr_valid), 32'h1);
    chk("slow_pc_out", 32'(pc_out), 32'h003);

    // decode back-pressure
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_pc_out", 32'(pc_out), 32'h003);
      chk("stall_instr", 32'(instr_out), 32'h103);
      chk("stall_no_req", 32'(imem_req), 32'h0);
    end
    instr_ready = 1'b1;
    ack_lat = 0;
    cycle();
    chk("resume_addr", 32'(imem_addr), 32'h004);
    cycle();
    chk("resume_pc_out", 32'(pc_out), 32'h004);

    // redirect while a request to 0x005 is still waiting for ack
    ack_lat = 2;
    cycle();
    chk("pend_addr", 32'(imem_addr), 32'h005);
    br_valid = 1'b1; br_target = 12'h040;
    cycle();
    br_valid = 1'b0;
    chk("stale_addr", 32'(imem_addr), 32'h005);
    cycle();
    chk("stale_addr2", 32'(imem_addr), 32'h005);
    cycle();
    chk("redir_req", 32'(imem_req), 32'h1);
    chk("redir_addr", 32'(imem_addr), 32'h040);
    chk("redir_valid_lo", 32'(instr_valid), 32'h0);
    wait_valid(10);
    chk("redir_pc_out", 32'(pc_out), 32'h040);
    chk("redir_instr", 32'(instr_out), 32'h140);

    // redirect in S_HOLD together with ready
    br_valid = 1'b1; br_target = 12'h080;
    cycle();
    br_valid = 1'b0;
    ack_lat = 0;
    chk("hold_br_valid", 32'(instr_valid), 32'h0);
    chk("hold_br_addr", 32'(imem_addr), 32'h080);
    wait_valid(10);
    chk("hold_br_pc_out", 32'(pc_out), 32'h080);

    // PC wrap at the top of the address space
    br_valid = 1'b1; br_target = 12'hFFF; instr_ready = 1'b0;
    cycle();
    br_valid = 1'b0; instr_ready = 1'b1;
    chk("wrap_top_addr", 32'(imem_addr), 32'hFFF);
    cycle();
    chk("wrap_top_pc_out", 32'(pc_out), 32'hFFF);
    chk("wrap_top_instr", 32'(instr_out), 32'h10FF);
    cycle();
    chk("wrap_addr", 32'(imem_addr), 32'h000);

    // redirect in the same cycle as ack
    br_valid = 1'b1; br_target = 12'h123;
    cycle();
    br_valid = 1'b0;
    chk("ackbr_valid", 32'(instr_valid), 32'h0);
    chk("ackbr_addr", 32'(imem_addr), 32'h123);
    cycle();
    chk("ackbr_pc_out", 32'(pc_out), 32'h123);
    chk("ackbr_instr", 32'(instr_out), 32'h223);

    // asynchronous reset in the middle of a request
    ack_lat = 5;
    cycle();
    chk("mid_req", 32'(imem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_req", 32'(imem_req), 32'h0);
    chk("async_valid", 32'(instr_valid), 32'h0);
    chk("async_addr", 32'(imem_addr), 32'h000);
    @(posedge clk);
    #1;
    rst = 1'b0; imem_ack = 1'b0; wait_cnt = 0; ack_lat = 0;
    model_reset();
    cycle();
    chk("restart_req", 32'(imem_req), 32'h1);
    chk("restart_addr", 32'(imem_addr), 32'h000);
    cycle();
    chk("restart_pc_out", 32'(pc_out), 32'h000);

    // randomized traffic against the stream model
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    imem_ack = 1'b0; wait_cnt = 0; br_valid = 1'b0;
    mem_scr = 1'b1; rnd_ack = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      cycle();
      instr_ready = ($urandom_range(0, 9) < 7);
      if (!br_valid && $urandom_range(0, 11) == 0) begin
        br_valid  = 1'b1;
        br_target = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1))
                                                : 12'($urandom);
      end else begin
        br_valid = 1'b0;
      end
    end
    br_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
